// File: rtl/hazard_controller.sv
// Interlock and forwarding controller for the 5-stage RV32I pipeline.
// Tracks in-flight register writers in EX/MEM/WB and derives stall, flush and forward selects.
module hazard_controller #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned REG_AW       = 5
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  input  logic              rs1_used_i,
  input  logic              rs2_used_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic              rd_wen_i,
  input  logic              is_load_i,
  input  logic              branch_taken_i,
  input  logic              ext_stall_i,
  output logic              stall_o,
  output logic              flush_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              busy_o
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              wen;
    logic              load;
  } slot_t;

  localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES);

  slot_t      ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [2:0] flush_cnt_q, flush_cnt_d;
  logic       haz_a, haz_b;
  logic       issue;

  function automatic logic slot_match(input slot_t s, input logic used,
                                      input logic [REG_AW-1:0] addr);
    return used & s.valid & s.wen & (s.rd == addr);
  endfunction

  // Youngest matching writer wins; a load still in EX/MEM has no data yet.
  function automatic logic [2:0] src_sel(input logic used, input logic [REG_AW-1:0] addr,
                                         input slot_t ex, input slot_t mem, input slot_t wb);
    logic [2:0] r;
    r = 3'b000;
    if (slot_match(ex, used, addr)) begin
      r = ex.load ? 3'b100 : 3'b001;
    end else if (slot_match(mem, used, addr)) begin
      r = mem.load ? 3'b100 : 3'b010;
    end else if (slot_match(wb, used, addr)) begin
      r = 3'b011;
    end
    return r;
  endfunction

  always_comb begin
    logic [2:0] sel_a, sel_b;
    sel_a   = src_sel(rs1_used_i, rs1_addr_i, ex_q, mem_q, wb_q);
    sel_b   = src_sel(rs2_used_i, rs2_addr_i, ex_q, mem_q, wb_q);
    haz_a   = sel_a[2];
    haz_b   = sel_b[2];
    fwd_a_o = sel_a[1:0];
    fwd_b_o = sel_b[1:0];
  end

  always_comb begin
    flush_o = (flush_cnt_q != 3'd0);
    stall_o = id_valid_i & (haz_a | haz_b) & ~flush_o;
    busy_o  = ex_q.valid | mem_q.valid | wb_q.valid;
    issue   = id_valid_i & ~stall_o & ~flush_o & ~ext_stall_i;
  end

  always_comb begin
    ex_d        = ex_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    flush_cnt_d = flush_cnt_q;
    if (!ext_stall_i) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = '0;
      if (issue) begin
        ex_d.valid = 1'b1;
        ex_d.rd    = rd_addr_i;
        ex_d.wen   = rd_wen_i & (rd_addr_i != '0);
        ex_d.load  = is_load_i;
      end
      if (branch_taken_i) begin
        flush_cnt_d = FlushLoad;
      end else if (flush_cnt_q != 3'd0) begin
        flush_cnt_d = flush_cnt_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      flush_cnt_q <= 3'd0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed pipeline scenarios plus random traffic
// compared against an in-flight instruction list model.
module tb_hazard_controller;

  localparam int FlushCycles = 2;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       id_valid_i;
  logic [4:0] rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic       rs1_used_i, rs2_used_i, rd_wen_i, is_load_i;
  logic       branch_taken_i, ext_stall_i;
  logic       stall_o, flush_o, busy_o;
  logic [1:0] fwd_a_o, fwd_b_o;

  hazard_controller #(
    .FLUSH_CYCLES(FlushCycles),
    .REG_AW      (5)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .id_valid_i    (id_valid_i),
    .rs1_addr_i    (rs1_addr_i),
    .rs2_addr_i    (rs2_addr_i),
    .rs1_used_i    (rs1_used_i),
    .rs2_used_i    (rs2_used_i),
    .rd_addr_i     (rd_addr_i),
    .rd_wen_i      (rd_wen_i),
    .is_load_i     (is_load_i),
    .branch_taken_i(branch_taken_i),
    .ext_stall_i   (ext_stall_i),
    .stall_o       (stall_o),
    .flush_o       (flush_o),
    .fwd_a_o       (fwd_a_o),
    .fwd_b_o       (fwd_b_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: instructions in flight, index 0 = youngest (in EX). Bubbles are kept as empty entries.
  typedef struct {
    bit valid;
    int rd;
    bit writes;
    bit load;
  } instr_t;

  instr_t pipe[3];
  int     flush_left;

  // Observed values captured at the last step's sample point.
  int last_stall, last_flush, last_fa, last_fb, last_busy;

  task automatic model_clear();
    for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
    flush_left = 0;
  endtask

  // Returns forward select, sets haz when the producer cannot supply its value yet.
  function automatic int model_src(input bit used, input int addr, output bit haz);
    haz = 0;
    if (!used || addr == 0) return 0;
    for (int i = 0; i < 3; i++) begin
      if (pipe[i].valid && pipe[i].writes && pipe[i].rd == addr) begin
        if (pipe[i].load && i < 2) begin
          haz = 1;
          return 0;
        end
        return i + 1;
      end
    end
    return 0;
  endfunction

  // Drive one cycle's decode inputs (caller is at a negedge), check, advance model.
  task automatic step(input bit v, input int r1, input int r2, input bit u1, input bit u2,
                      input int rd, input bit wen, input bit ld, input bit br, input bit es);
    bit ha, hb, e_flush, e_stall, e_issue, any_valid;
    int e_fa, e_fb;
    id_valid_i     = v;
    rs1_addr_i     = 5'(r1);
    rs2_addr_i     = 5'(r2);
    rs1_used_i     = u1;
    rs2_used_i     = u2;
    rd_addr_i      = 5'(rd);
    rd_wen_i       = wen;
    is_load_i      = ld;
    branch_taken_i = br;
    ext_stall_i    = es;
    #1;
    e_fa      = model_src(u1, r1, ha);
    e_fb      = model_src(u2, r2, hb);
    e_flush   = (flush_left > 0);
    e_stall   = v && (ha || hb) && !e_flush;
    any_valid = pipe[0].valid || pipe[1].valid || pipe[2].valid;
    last_stall = int'(stall_o);
    last_flush = int'(flush_o);
    last_fa    = int'(fwd_a_o);
    last_fb    = int'(fwd_b_o);
    last_busy  = int'(busy_o);
    check_eq("stall", last_stall, int'(e_stall));
    check_eq("flush", last_flush, int'(e_flush));
    check_eq("fwd_a", last_fa, e_fa);
    check_eq("fwd_b", last_fb, e_fb);
    check_eq("busy", last_busy, int'(any_valid));
    e_issue = v && !e_stall && !e_flush && !es;
    if (!es) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = e_issue ? instr_t'{1, rd, wen && rd != 0, ld} : instr_t'{0, 0, 0, 0};
      if (br) flush_left = FlushCycles;
      else if (flush_left > 0) flush_left--;
    end
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    reset_i = 1'b1;
    #1;
    check_eq("rst_stall", int'(stall_o), 0);
    check_eq("rst_flush", int'(flush_o), 0);
    check_eq("rst_fwd_a", int'(fwd_a_o), 0);
    check_eq("rst_fwd_b", int'(fwd_b_o), 0);
    check_eq("rst_busy", int'(busy_o), 0);
    model_clear();
    @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1;
    id_valid_i = 0; rs1_addr_i = 0; rs2_addr_i = 0; rs1_used_i = 0; rs2_used_i = 0;
    rd_addr_i = 0; rd_wen_i = 0; is_load_i = 0; branch_taken_i = 0; ext_stall_i = 0;
    model_clear();
    @(negedge clk_i);
    do_reset();

    // addi x5,x0,1 ; add x6,x5,x5
    step(1, 0, 0, 1, 0, 5, 1, 0, 0, 0);
    step(1, 5, 5, 1, 1, 6, 1, 0, 0, 0);
    check_eq("tp1_fwd_a", last_fa, 1);
    check_eq("tp1_fwd_b", last_fb, 1);
    check_eq("tp1_stall", last_stall, 0);
    idle(3);

    // addi x5 ; nop ; nop ; add x6,x5,x0
    step(1, 0, 0, 1, 0, 5, 1, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    step(1, 5, 0, 1, 1, 6, 1, 0, 0, 0);
    check_eq("tp2_fwd_a", last_fa, 3);
    check_eq("tp2_fwd_b", last_fb, 0);
    idle(3);

    // lw x7,0(x1) ; add x8,x7,x2 held until the load reaches WB
    step(1, 1, 0, 1, 0, 7, 1, 1, 0, 0);
    step(1, 7, 2, 1, 1, 8, 1, 0, 0, 0);
    check_eq("tp3_stall1", last_stall, 1);
    step(1, 7, 2, 1, 1, 8, 1, 0, 0, 0);
    check_eq("tp3_stall2", last_stall, 1);
    step(1, 7, 2, 1, 1, 8, 1, 0, 0, 0);
    check_eq("tp3_stall3", last_stall, 0);
    check_eq("tp3_fwd_a", last_fa, 3);
    idle(3);

    // Taken branch while a load-use hazard is pending: flush overrides stall
    step(1, 1, 0, 1, 0, 7, 1, 1, 0, 0);
    step(1, 7, 2, 1, 1, 8, 1, 0, 1, 0);
    step(1, 7, 2, 1, 1, 8, 1, 0, 0, 0);
    check_eq("tp4_flush1", last_flush, 1);
    check_eq("tp4_stall1", last_stall, 0);
    step(1, 7, 2, 1, 1, 8, 1, 0, 0, 0);
    check_eq("tp4_flush2", last_flush, 1);
    check_eq("tp4_stall2", last_stall, 0);
    idle(3);

    // External stall freezes a flush with one cycle remaining
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      check_eq("tp5_frozen", last_flush, 1);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("tp5_last", last_flush, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("tp5_drop", last_flush, 0);
    idle(2);

    // Writes to x0 (including a load) never forward or stall
    step(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    step(1, 0, 0, 1, 1, 9, 1, 0, 0, 0);
    check_eq("tp6_fwd_a", last_fa, 0);
    check_eq("tp6_fwd_b", last_fb, 0);
    check_eq("tp6_stall", last_stall, 0);
    idle(3);

    // Reset asserted during a load-use stall
    step(1, 1, 0, 1, 0, 7, 1, 1, 0, 0);
    step(1, 7, 2, 1, 1, 8, 1, 0, 0, 0);
    check_eq("tp7_stall", last_stall, 1);
    do_reset();
    step(1, 7, 2, 1, 1, 8, 1, 0, 0, 0);
    check_eq("tp7_post_stall", last_stall, 0);
    idle(2);

    // Random traffic over a small register set to provoke dependencies
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
             int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0,
             $urandom_range(0, 7) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline interlock and forwarding controller for the 5-stage RV32I core (IF, ID, EX, MEM, WB).
- Sits beside the decode stage and keeps its own scoreboard of in-flight register writers in EX, MEM and WB.
- From that scoreboard it produces the decode `stall`, the taken-branch flush and the operand-forwarding selects for the EX stage.
- Also freezes the scoreboard while an external stall (data-memory or display busy) is active.

Parameters:
- FLUSH_CYCLES, 2, number of cycles `flush_o` stays high after a taken branch/jump (1..7).
- REG_AW, 5, register address width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- id_valid_i  in  1  decode holds a valid instruction.
- rs1_addr_i  in  REG_AW  decode rs1 address.
- rs2_addr_i  in  REG_AW  decode rs2 address.
- rs1_used_i  in  1  instruction reads rs1.
- rs2_used_i  in  1  instruction reads rs2.
- rd_addr_i  in  REG_AW  decode destination register.
- rd_wen_i  in  1  decode instruction writes rd.
- is_load_i  in  1  decode instruction is a load.
- branch_taken_i  in  1  EX resolved a taken branch/JAL/JALR (1-cycle pulse).
- ext_stall_i  in  1  memory/display busy; freezes the whole pipeline.
- stall_o  out  1  hold IF/ID, inject bubble into EX.
- flush_o  out  1  squash IF/ID contents.
- fwd_a_o  out  2  EX op1 source: 0=RF, 1=EX result, 2=MEM result, 3=WB data.
- fwd_b_o  out  2  EX op2 source, same encoding as `fwd_a_o`.
- busy_o  out  1  any scoreboard slot valid.

Behaviour:
- Scoreboard: three slots EX, MEM, WB. Each slot holds {valid, rd, wen, load}.
  - A slot's `wen` is forced to 0 when `rd` = 0.
- Issue condition: `issue` = `id_valid_i` & !`stall_o` & !`flush_o` & !`ext_stall_i`.
- Each clock with `ext_stall_i` = 0:
  - WB <= MEM; MEM <= EX.
  - EX <= {1, `rd_addr_i`, `rd_wen_i`, `is_load_i`} if `issue`, else the bubble value (all zero).
- Each clock with `ext_stall_i` = 1: all slots hold and the flush counter holds.
- Match for a source s: `rsX_used_i` & slot.valid & slot.wen & slot.rd = `rsX_addr_i`.
- Forward select: priority EX > MEM > WB.
  - A matching EX or MEM slot with `load` = 1 gives no forward and raises a hazard.
  - A WB load match forwards WB (select 3).
  - No match gives select 0.
- Load-use hazard: `stall_o` = `id_valid_i` & (load hazard on rs1 or rs2) & !`flush_o`.
  - Combinational.
  - A dependent instruction directly after a load stalls 2 cycles; one instruction later it stalls 1 cycle.
- Flush counter (3 bits):
  - On `branch_taken_i` with `ext_stall_i` = 0, load FLUSH_CYCLES.
  - Otherwise decrement while nonzero and `ext_stall_i` = 0.
  - `flush_o` = (counter != 0), registered.
  - A `branch_taken_i` arriving while the counter is nonzero reloads FLUSH_CYCLES.
- Simultaneous flush and hazard: flush wins. `stall_o` = 0 and a bubble is issued.
- `fwd_a_o`/`fwd_b_o` are combinational from the current slots.
  - They are 0 whenever the matching source is unused.
- Reset (async, immediate):
  - All slots invalid, counter 0.
  - `stall_o` = 0, `flush_o` = 0, `fwd_a_o` = 0, `fwd_b_o` = 0, `busy_o` = 0.
  - A reset mid-flush or mid-stall clears everything; the first post-reset cycle issues normally.
- x0 never causes a hazard or a forward.

Test Plan:
- addi x5,x0,1 then add x6,x5,x5 -> cycle 2: `fwd_a_o` = 1, `fwd_b_o` = 1, `stall_o` = 0.
- addi x5; nop; nop; add x6,x5,x0 -> on add: `fwd_a_o` = 3, `fwd_b_o` = 0.
- lw x7,0(x1) then add x8,x7,x2 -> `stall_o` = 1 for 2 cycles, then `fwd_a_o` = 3, `stall_o` = 0.
- `branch_taken_i` pulse while a load-use hazard is pending -> `flush_o` = 1 for 2 cycles, `stall_o` = 0 throughout, EX slot bubbles.
- `ext_stall_i` = 1 for 3 cycles mid-flush (counter = 1) -> slots and `flush_o` frozen; `flush_o` drops 1 cycle after release.
- Writes to x0 followed by reads of x0 -> `fwd_a_o` = `fwd_b_o` = 0, `stall_o` = 0.
- Assert `reset_i` during a stall -> outputs 0 asynchronously, `busy_o` = 0.
